// File: rtl/ssram_ctrl.sv
// ssram_ctrl: ZBT-style pipelined SSRAM controller (36-bit, 4 x 9-bit lanes).
// Turns user burst read/write commands into registered pin activity with no
// bus-turnaround idle cycles. Pin timing, with cycle C being the cycle in
// which the registered address/control pins hold a beat:
//   write beat : DQ driven with the beat's data during cycle C+2 only
//   read beat  : DQ captured at the posedge ending C+2, rd_* visible in C+3
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high; valid must not wait on ready, and ready is
// a pure function of controller state (never of the same-side valid).
//   cmd_valid/cmd_ready : one burst command per transfer
//   wr_valid/wr_ready   : one write beat per transfer (FWFT source)
//   rd_valid            : no backpressure, consumer must take every beat
module ssram_ctrl #(
  parameter int AW = 28,
  parameter int DW = 36,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  // command port
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  // write data port
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic [3:0]    wr_be,
  // read data port
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  // SSRAM pins
  output logic [AW-1:0] SRAM_ADDR,
  inout  wire  [8:0]    SRAM_DA,
  inout  wire  [8:0]    SRAM_DB,
  inout  wire  [8:0]    SRAM_DC,
  inout  wire  [8:0]    SRAM_DD,
  output logic          SRAM_CEn,
  output logic          SRAM_WEn,
  output logic          SRAM_BWan,
  output logic          SRAM_BWbn,
  output logic          SRAM_BWcn,
  output logic          SRAM_BWdn,
  output logic          SRAM_CLK,
  output logic          SRAM_MODE,
  output logic          SRAM_CE2,
  output logic          SRAM_CE2n,
  output logic          SRAM_OEn,
  output logic          SRAM_CLKEn,
  output logic          SRAM_ZZ,
  output logic          SRAM_ADV,
  // debug: current FSM state
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  // FSM
  state_t        r_state;
  state_t        w_state_nxt;

  // burst bookkeeping
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_cnt;

  // registered pins
  logic [AW-1:0] r_sram_addr;
  logic          r_cen;
  logic          r_wen;
  logic [3:0]    r_bwn;

  // write data pipe: stage 1 lines up with cycle C, stage 2 with C+1,
  // the output register (r_oe/r_dq_out) with C+2
  logic          r_wv1;
  logic          r_wv2;
  logic          r_oe;
  logic [DW-1:0] r_wd1;
  logic [DW-1:0] r_wd2;
  logic [DW-1:0] r_dq_out;

  // read tag pipe: bit 0 lines up with cycle C, bit 2 with C+2
  logic [2:0]    r_rv;
  logic [2:0]    r_rl;

  // read return registers
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_last;

  // combinational control
  logic          w_cmd_ready;
  logic          w_wr_ready;
  logic          w_accept;
  logic          w_issue;
  logic          w_issue_we;
  logic          w_last;
  logic [DW-1:0] w_dq_in;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, handshake readies and beat issue decision
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_issue     = 1'b0;
    w_issue_we  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
      end
      S_WR: begin
        w_wr_ready = 1'b1;
        // a missing write beat becomes a NOP cycle; the count does not move
        if (wr_valid) begin
          w_issue    = 1'b1;
          w_issue_we = 1'b1;
          w_last     = (r_cnt == '0);
        end
      end
      S_RD: begin
        w_issue = 1'b1;
        w_last  = (r_cnt == '0);
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // the last beat of a burst can accept the next command so bursts chain
    // without an idle cycle, in either direction
    if (w_last) begin
      w_cmd_ready = 1'b1;
    end
    if (rst) begin
      w_cmd_ready = 1'b0;
      w_wr_ready  = 1'b0;
    end
    w_accept = cmd_valid & w_cmd_ready;
    if (w_accept) begin
      w_state_nxt = cmd_we ? S_WR : S_RD;
    end else if (w_last) begin
      w_state_nxt = S_IDLE;
    end
  end

  // burst address and remaining-beat counter (address wraps mod 2^AW)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_addr <= cmd_addr;
      r_cnt  <= cmd_len;
    end else if (w_issue) begin
      r_addr <= r_addr + 1'b1;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // registered SSRAM address/control pins; NOP cycles keep the last address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_cen       <= 1'b1;
      r_wen       <= 1'b1;
      r_bwn       <= 4'hF;
    end else if (w_issue) begin
      r_sram_addr <= r_addr;
      r_cen       <= 1'b0;
      r_wen       <= ~w_issue_we;
      r_bwn       <= w_issue_we ? ~wr_be : 4'h0;
    end else begin
      r_cen       <= 1'b1;
      r_wen       <= 1'b1;
      r_bwn       <= 4'hF;
    end
  end

  // write data pipe: the beat's data reaches the DQ drivers two cycles after
  // its address, matching the SSRAM's late-write data phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wv1    <= 1'b0;
      r_wv2    <= 1'b0;
      r_oe     <= 1'b0;
      r_wd1    <= '0;
      r_wd2    <= '0;
      r_dq_out <= '0;
    end else begin
      r_wv1 <= w_issue & w_issue_we;
      if (w_issue && w_issue_we) begin
        r_wd1 <= wr_data;
      end
      r_wv2    <= r_wv1;
      r_wd2    <= r_wd1;
      r_oe     <= r_wv2;
      r_dq_out <= r_wd2;
    end
  end

  // read tag pipe: follows each read beat to the cycle its data is on DQ
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rv <= 3'b000;
      r_rl <= 3'b000;
    end else begin
      r_rv <= {r_rv[1:0], w_issue & ~w_issue_we};
      r_rl <= {r_rl[1:0], w_issue & ~w_issue_we & w_last};
    end
  end

  // read capture: sample DQ at the end of C+2, present in C+3
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= r_rv[2];
      r_rd_last  <= r_rv[2] & r_rl[2];
      if (r_rv[2]) begin
        r_rd_data <= w_dq_in;
      end
    end
  end

  // DQ lanes: driven only in a write beat's data cycle. A read's data cycle
  // and a following write's data cycle never coincide, so switching
  // direction needs no idle cycle.
  assign SRAM_DA = r_oe ? r_dq_out[8:0]   : 9'bz;
  assign SRAM_DB = r_oe ? r_dq_out[17:9]  : 9'bz;
  assign SRAM_DC = r_oe ? r_dq_out[26:18] : 9'bz;
  assign SRAM_DD = r_oe ? r_dq_out[35:27] : 9'bz;
  assign w_dq_in = {SRAM_DD, SRAM_DC, SRAM_DB, SRAM_DA};

  assign cmd_ready   = w_cmd_ready;
  assign wr_ready    = w_wr_ready;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  // busy covers every beat still in the pin pipeline, up to the final
  // write's drive cycle and the final read's rd_valid cycle
  assign busy        = (r_state != S_IDLE) | r_wv1 | r_wv2 | r_oe |
                       (|r_rv) | r_rd_valid;
  assign o_dbg_state = r_state;

  assign SRAM_ADDR  = r_sram_addr;
  assign SRAM_CEn   = r_cen;
  assign SRAM_WEn   = r_wen;
  assign SRAM_BWan  = r_bwn[0];
  assign SRAM_BWbn  = r_bwn[1];
  assign SRAM_BWcn  = r_bwn[2];
  assign SRAM_BWdn  = r_bwn[3];
  assign SRAM_CLK   = clk;
  assign SRAM_MODE  = 1'b0;
  assign SRAM_CE2   = 1'b1;
  assign SRAM_CE2n  = 1'b0;
  assign SRAM_OEn   = 1'b0;
  assign SRAM_CLKEn = 1'b0;
  assign SRAM_ZZ    = 1'b0;
  assign SRAM_ADV   = 1'b0;

endmodule

// File: tb/tb_ssram_ctrl.sv
// tb_ssram_ctrl: directed bench for ssram_ctrl with a small pipelined
// ZBT SSRAM model on the pins.
module tb_ssram_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [27:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [35:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_valid;
  logic [35:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic [27:0] sram_addr;
  wire  [8:0]  sram_da, sram_db, sram_dc, sram_dd;
  logic        sram_cen, sram_wen, bwa, bwb, bwc, bwd;
  logic        sram_clk, sram_mode, sram_ce2, sram_ce2n, sram_oen;
  logic        sram_clken, sram_zz, sram_adv;
  logic [1:0]  dbg_state;

  ssram_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .SRAM_ADDR(sram_addr),
    .SRAM_DA(sram_da), .SRAM_DB(sram_db), .SRAM_DC(sram_dc), .SRAM_DD(sram_dd),
    .SRAM_CEn(sram_cen), .SRAM_WEn(sram_wen),
    .SRAM_BWan(bwa), .SRAM_BWbn(bwb), .SRAM_BWcn(bwc), .SRAM_BWdn(bwd),
    .SRAM_CLK(sram_clk), .SRAM_MODE(sram_mode), .SRAM_CE2(sram_ce2),
    .SRAM_CE2n(sram_ce2n), .SRAM_OEn(sram_oen), .SRAM_CLKEn(sram_clken),
    .SRAM_ZZ(sram_zz), .SRAM_ADV(sram_adv),
    .o_dbg_state(dbg_state)
  );

  // ---------------- SSRAM model (pipelined, 2-cycle data phase) ----------------
  logic [35:0] mem [logic [27:0]];
  logic        m_v0 = 1'b0, m_we0 = 1'b0, m_v1 = 1'b0, m_we1 = 1'b0;
  logic [27:0] m_a0 = '0, m_a1 = '0;
  logic [3:0]  m_bw0 = 4'hF, m_bw1 = 4'hF;
  logic        m_drv = 1'b0;
  logic [35:0] m_rd = '0;
  logic [35:0] m_cur;
  logic [35:0] m_bus;

  function automatic logic [35:0] mem_rd(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return 36'h0;
  endfunction

  assign m_bus = {sram_dd, sram_dc, sram_db, sram_da};
  assign sram_da = m_drv ? m_rd[8:0]   : 9'bz;
  assign sram_db = m_drv ? m_rd[17:9]  : 9'bz;
  assign sram_dc = m_drv ? m_rd[26:18] : 9'bz;
  assign sram_dd = m_drv ? m_rd[35:27] : 9'bz;

  always @(posedge clk) begin
    // write data of the command issued two cycles ago is on the bus now
    if (m_v1 && m_we1) begin
      m_cur = mem_rd(m_a1);
      for (int l = 0; l < 4; l++) begin
        if (!m_bw1[l]) m_cur[l*9 +: 9] = m_bus[l*9 +: 9];
      end
      mem[m_a1] = m_cur;
    end
    // read data of the command issued last cycle goes on the bus next cycle
    m_drv <= m_v0 && !m_we0;
    m_rd  <= mem_rd(m_a0);
    m_v1  <= m_v0;  m_we1 <= m_we0;  m_a1 <= m_a0;  m_bw1 <= m_bw0;
    m_v0  <= !sram_cen;
    m_we0 <= !sram_wen;
    m_a0  <= sram_addr;
    m_bw0 <= {bwd, bwc, bwb, bwa};
  end

  // ---------------- pin / read-port monitor ----------------
  int          cyc = 0;
  logic [27:0] beat_a[$];
  logic        beat_we[$];
  logic [3:0]  beat_bw[$];
  int          beat_c[$];
  logic [35:0] rd_d[$];
  logic        rd_l[$];
  int          rd_c[$];
  int          oe_cnt = 0;
  int          oe_c = 0;

  always @(negedge clk) begin
    cyc++;
    if (!sram_cen) begin
      beat_a.push_back(sram_addr);
      beat_we.push_back(!sram_wen);
      beat_bw.push_back({bwd, bwc, bwb, bwa});
      beat_c.push_back(cyc);
    end
    if (rd_valid) begin
      rd_d.push_back(rd_data);
      rd_l.push_back(rd_last);
      rd_c.push_back(cyc);
    end
    if (dut.r_oe) begin
      oe_cnt++;
      oe_c = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_count"}, 64'(rd_d.size()), 64'(exp_q.size()));
    for (int i = 0; i < rd_d.size() && i < exp_q.size(); i++) begin
      check({tag, "_data"}, 64'(rd_d[i]), 64'(exp_q[i]));
      check({tag, "_last"}, 64'(rd_l[i]), 64'(i == exp_q.size() - 1));
    end
    exp_q.delete();
  endtask

  task automatic clear_logs();
    beat_a.delete(); beat_we.delete(); beat_bw.delete(); beat_c.delete();
    rd_d.delete(); rd_l.delete(); rd_c.delete();
    oe_cnt = 0;
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_cmd(input logic we, input logic [27:0] a, input logic [7:0] len);
    int t;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    t = 0;
    #1;
    while (!cmd_ready && t < 40) begin
      @(negedge clk); #1; t++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [35:0] d, input logic [3:0] be);
    int t;
    wr_valid = 1'b1; wr_data = d; wr_be = be;
    t = 0;
    #1;
    while (!wr_ready && t < 40) begin
      @(negedge clk); #1; t++;
    end
    check("wr_accept", 64'(wr_ready), 64'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    #1;
    while (busy && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_cen", 64'(sram_cen), 64'd1);
    check("rst_wen", 64'(sram_wen), 64'd1);
    check("rst_bw", 64'({bwd, bwc, bwb, bwa}), 64'hF);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_rd", 64'({rd_valid, rd_last, rd_data}), 64'd0);
    check("rst_ready", 64'({cmd_ready, wr_ready, busy}), 64'd0);
    check("const_pins", 64'({sram_mode, sram_ce2, sram_ce2n, sram_oen,
                             sram_clken, sram_zz, sram_adv}), 64'b0100000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // 1: single write then single read at 0x10
    clear_logs();
    send_cmd(1'b1, 28'h0000010, 8'd0);
    send_wr(36'h123456789, 4'hF);
    wait_idle();
    check("t1_wbeats", 64'(beat_a.size()), 64'd1);
    if (beat_a.size() == 1) begin
      check("t1_waddr", 64'(beat_a[0]), 64'h10);
      check("t1_wwe", 64'(beat_we[0]), 64'd1);
      check("t1_oe_lat", 64'(oe_c - beat_c[0]), 64'd2);
    end
    check("t1_oe_cnt", 64'(oe_cnt), 64'd1);
    clear_logs();
    send_cmd(1'b0, 28'h0000010, 8'd0);
    wait_idle();
    exp_q.push_back(36'h123456789);
    if (rd_c.size() == 1 && beat_c.size() == 1)
      check("t1_rd_lat", 64'(rd_c[0] - beat_c[0]), 64'd3);
    check_reads("t1_rd");

    // 2: lane enables
    send_cmd(1'b1, 28'h0000020, 8'd0);
    send_wr(36'hFFFFFFFFF, 4'hF);
    wait_idle();
    clear_logs();
    send_cmd(1'b1, 28'h0000020, 8'd0);
    send_wr(36'h000000000, 4'b0101);
    wait_idle();
    if (beat_bw.size() == 1) check("t2_bwn", 64'(beat_bw[0]), 64'b1010);
    clear_logs();
    send_cmd(1'b0, 28'h0000020, 8'd0);
    wait_idle();
    exp_q.push_back(36'hFF803FE00);
    check_reads("t2_rd");

    // 3: wrapping 4-beat write with one missing beat, then read back
    clear_logs();
    send_cmd(1'b1, 28'hFFFFFFE, 8'd3);
    send_wr(36'h00000A001, 4'hF);
    send_wr(36'h1FF00B002, 4'hF);
    @(negedge clk);
    send_wr(36'h80000C003, 4'hF);
    send_wr(36'h5A5A5A5A5, 4'hF);
    wait_idle();
    check("t3_wbeats", 64'(beat_a.size()), 64'd4);
    if (beat_a.size() == 4) begin
      check("t3_addr0", 64'(beat_a[0]), 64'hFFFFFFE);
      check("t3_addr1", 64'(beat_a[1]), 64'hFFFFFFF);
      check("t3_addr2", 64'(beat_a[2]), 64'h0000000);
      check("t3_addr3", 64'(beat_a[3]), 64'h0000001);
      check("t3_nop_gap", 64'(beat_c[2] - beat_c[1]), 64'd2);
      check("t3_span", 64'(beat_c[3] - beat_c[0]), 64'd4);
    end
    clear_logs();
    send_cmd(1'b0, 28'hFFFFFFE, 8'd3);
    wait_idle();
    if (rd_c.size() == 4) check("t3_rd_consec", 64'(rd_c[3] - rd_c[0]), 64'd3);
    exp_q.push_back(36'h00000A001);
    exp_q.push_back(36'h1FF00B002);
    exp_q.push_back(36'h80000C003);
    exp_q.push_back(36'h5A5A5A5A5);
    check_reads("t3_rd");

    // 4: read burst with a write accepted on its last beat
    send_cmd(1'b1, 28'h0000040, 8'd1);
    send_wr(36'h111111111, 4'hF);
    send_wr(36'h222222222, 4'hF);
    wait_idle();
    clear_logs();
    send_cmd(1'b0, 28'h0000040, 8'd1);
    send_cmd(1'b1, 28'h0000050, 8'd0);
    send_wr(36'h987654321, 4'hF);
    wait_idle();
    check("t4_beats", 64'(beat_a.size()), 64'd3);
    if (beat_a.size() == 3) begin
      check("t4_we_pat", 64'({beat_we[0], beat_we[1], beat_we[2]}), 64'b001);
      check("t4_addr2", 64'(beat_a[2]), 64'h50);
      check("t4_no_nop", 64'(beat_c[2] - beat_c[0]), 64'd2);
    end
    check("t4_oe_cnt", 64'(oe_cnt), 64'd1);
    exp_q.push_back(36'h111111111);
    exp_q.push_back(36'h222222222);
    check_reads("t4_rd");
    clear_logs();
    send_cmd(1'b0, 28'h0000050, 8'd0);
    wait_idle();
    exp_q.push_back(36'h987654321);
    check_reads("t4_wr_rd");

    // 5: reset in cycle C+1 of a read burst
    clear_logs();
    send_cmd(1'b0, 28'h0000010, 8'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 64'({cmd_ready, wr_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t5_cen_wen", 64'({sram_cen, sram_wen}), 64'b11);
    check("t5_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    check("t5_no_rd", 64'(rd_d.size()), 64'd0);
    check("t5_beats", 64'(beat_a.size()), 64'd2);
    clear_logs();
    send_cmd(1'b0, 28'h0000010, 8'd0);
    wait_idle();
    exp_q.push_back(36'h123456789);
    check_reads("t5_recover");

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
